// File: rtl/mem_loader_pkg.sv
// Shared opcodes, memory-select values and loader FSM state encoding.
package mem_loader_pkg;

    localparam logic [7:0] OP_WR_IMEM = 8'h01;
    localparam logic [7:0] OP_WR_DMEM = 8'h02;
    localparam logic [7:0] OP_RUN     = 8'h03;
    localparam logic [7:0] OP_HALT    = 8'h04;

    localparam logic MEM_SEL_IMEM = 1'b0;
    localparam logic MEM_SEL_DMEM = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_LO,
        ST_ADDR_HI,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_DATA,
        ST_RUN
    } state_t;

    function automatic logic is_load_op(input logic [7:0] op);
        return (op == OP_WR_IMEM) || (op == OP_WR_DMEM);
    endfunction

endpackage

// File: rtl/mem_loader_word_assembler.sv
// Collects four little-endian bytes into a 32-bit word; word_valid marks the 4th byte.
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx;
    logic [23:0] shreg;

    // The 4th byte is combined directly so the caller can register the word on that edge.
    assign word_valid = byte_valid && (idx == 2'd3);
    assign word       = {byte_in, shreg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx   <= '0;
            shreg <= '0;
        end else if (clear) begin
            idx   <= '0;
            shreg <= '0;
        end else if (byte_valid) begin
            idx   <= idx + 2'd1;
            shreg <= {byte_in, shreg[23:8]};
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Byte-stream loader: frames bytes into IMEM/DMEM word writes and controls the CPU core reset.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              err
);

    state_t             state;
    logic               sel_q;
    logic [7:0]         addr_lo;
    logic [7:0]         cnt_lo;
    logic [ADDR_W-1:0]  waddr;
    logic [CNT_W-1:0]   remaining;
    logic               xfer;
    logic               asm_valid;
    logic               asm_clear;
    logic               word_valid;
    logic [31:0]        word;

    assign in_ready  = 1'b1;
    assign xfer      = in_valid && in_ready;
    assign asm_valid = xfer && (state == ST_DATA);
    assign asm_clear = xfer && (state == ST_CNT_HI);

    word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_in    (in_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            sel_q     <= MEM_SEL_IMEM;
            addr_lo   <= '0;
            cnt_lo    <= '0;
            waddr     <= '0;
            remaining <= '0;
            mem_we    <= 1'b0;
            mem_sel   <= MEM_SEL_IMEM;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (xfer) begin
                case (state)
                    ST_IDLE: begin
                        if (is_load_op(in_byte)) begin
                            sel_q <= (in_byte == OP_WR_DMEM) ? MEM_SEL_DMEM : MEM_SEL_IMEM;
                            state <= ST_ADDR_LO;
                            busy  <= 1'b1;
                        end else if (in_byte == OP_RUN) begin
                            state     <= ST_RUN;
                            cpu_reset <= 1'b0;
                        end else if (in_byte != OP_HALT) begin
                            err <= 1'b1;
                        end
                    end
                    ST_ADDR_LO: begin
                        addr_lo <= in_byte;
                        state   <= ST_ADDR_HI;
                    end
                    ST_ADDR_HI: begin
                        waddr <= ADDR_W'({in_byte, addr_lo});
                        state <= ST_CNT_LO;
                    end
                    ST_CNT_LO: begin
                        cnt_lo <= in_byte;
                        state  <= ST_CNT_HI;
                    end
                    ST_CNT_HI: begin
                        remaining <= CNT_W'({in_byte, cnt_lo});
                        if ({in_byte, cnt_lo} == 16'h0000) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (word_valid) begin
                            mem_we    <= 1'b1;
                            mem_sel   <= sel_q;
                            mem_addr  <= waddr;
                            mem_wdata <= word;
                            waddr     <= waddr + 1'b1;
                            remaining <= remaining - 1'b1;
                            if (remaining == CNT_W'(1)) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (in_byte == OP_HALT) begin
                            cpu_reset <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed frames followed by randomized frame mixes.
module tb_mem_loader;
    import mem_loader_pkg::*;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned AMASK  = (1 << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_byte = 8'h00;
    logic              in_ready;
    logic              mem_we;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              err;

    int checks = 0;
    int errors = 0;
    bit model_err = 1'b0;
    bit model_run = 1'b0;
    logic [31:0] wq[$];

    always #5 clk = ~clk;

    mem_loader #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One byte per cycle; outputs are checked 1 time unit after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit bsy, input bit we,
                             input bit sel, input int unsigned addr, input logic [31:0] data);
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        @(posedge clk);
        #1;
        chk("mem_we", 32'(mem_we), 32'(we));
        if (we) begin
            chk("mem_sel", 32'(mem_sel), 32'(sel));
            chk("mem_addr", 32'(mem_addr), addr);
            chk("mem_wdata", mem_wdata, data);
        end
        chk("busy", 32'(busy), 32'(bsy));
        chk("cpu_reset", 32'(cpu_reset), 32'(!model_run));
        chk("err", 32'(err), 32'(model_err));
        chk("in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_byte  = 8'($urandom);
            @(posedge clk);
            #1;
            chk("idle_mem_we", 32'(mem_we), 32'd0);
            chk("idle_cpu_reset", 32'(cpu_reset), 32'(!model_run));
        end
    endtask

    // Sends a full load frame carrying the words in wq.
    task automatic send_load(input bit dmem, input logic [15:0] start);
        logic [15:0] cnt;
        logic [31:0] w;
        int unsigned a;
        cnt = 16'(wq.size());
        send_byte(dmem ? OP_WR_DMEM : OP_WR_IMEM, 1'b1, 1'b0, 1'b0, 0, 0);
        send_byte(start[7:0], 1'b1, 1'b0, 1'b0, 0, 0);
        send_byte(start[15:8], 1'b1, 1'b0, 1'b0, 0, 0);
        send_byte(cnt[7:0], 1'b1, 1'b0, 1'b0, 0, 0);
        send_byte(cnt[15:8], cnt != 0, 1'b0, 1'b0, 0, 0);
        for (int unsigned i = 0; i < wq.size(); i++) begin
            w = wq[i];
            a = (int'(start) + i) & AMASK;
            for (int unsigned k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], !(k == 3 && i == wq.size() - 1), k == 3, dmem, a, w);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        model_run = 1'b0;
        model_err = 1'b0;
        #1;
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        logic [15:0] start;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("init_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("init_mem_we", 32'(mem_we), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_err", 32'(err), 32'd0);
        chk("init_in_ready", 32'(in_ready), 32'd1);
        chk("init_mem_addr", 32'(mem_addr), 32'd0);
        chk("init_mem_wdata", mem_wdata, 32'd0);
        chk("init_mem_sel", 32'(mem_sel), 32'd0);
        idle(2);

        // Two-word IMEM load at address 4
        wq = {32'h00500013, 32'h00100093};
        send_load(1'b0, 16'h0004);
        idle(2);
        chk("hold_mem_addr", 32'(mem_addr), 32'd5);
        chk("hold_mem_wdata", mem_wdata, 32'h00100093);

        // DMEM load wrapping from the top address to zero
        wq = {32'(($urandom)), 32'(($urandom))};
        send_load(1'b1, 16'h03FF);
        idle(1);

        // Zero-count frame, then RUN with ignored bytes, then HALT
        wq = {};
        send_load(1'b0, 16'h0123);
        model_run = 1'b1;
        send_byte(OP_RUN, 1'b0, 1'b0, 1'b0, 0, 0);
        send_byte(OP_WR_IMEM, 1'b0, 1'b0, 1'b0, 0, 0);
        send_byte(8'h7E, 1'b0, 1'b0, 1'b0, 0, 0);
        send_byte(OP_RUN, 1'b0, 1'b0, 1'b0, 0, 0);
        model_run = 1'b0;
        send_byte(OP_HALT, 1'b0, 1'b0, 1'b0, 0, 0);
        send_byte(OP_HALT, 1'b0, 1'b0, 1'b0, 0, 0);
        wq = {32'hA5A55A5A};
        send_load(1'b0, 16'h0010);

        // Unknown opcode sets a sticky error that survives a later load
        model_err = 1'b1;
        send_byte(8'h7E, 1'b0, 1'b0, 1'b0, 0, 0);
        wq = {32'hDEADBEEF, 32'h01234567};
        send_load(1'b0, 16'h0020);
        idle(1);
        do_reset();
        idle(1);

        // Reset two bytes into a word discards the partial word
        send_byte(OP_WR_DMEM, 1'b1, 1'b0, 1'b0, 0, 0);
        send_byte(8'h40, 1'b1, 1'b0, 1'b0, 0, 0);
        send_byte(8'h00, 1'b1, 1'b0, 1'b0, 0, 0);
        send_byte(8'h01, 1'b1, 1'b0, 1'b0, 0, 0);
        send_byte(8'h00, 1'b1, 1'b0, 1'b0, 0, 0);
        send_byte(8'hFF, 1'b1, 1'b0, 1'b0, 0, 0);
        send_byte(8'hEE, 1'b1, 1'b0, 1'b0, 0, 0);
        do_reset();
        idle(3);
        wq = {32'h00000011};
        send_load(1'b1, 16'h0041);

        // Reset while the core runs pulls cpu_reset high without a clock edge
        model_run = 1'b1;
        send_byte(OP_RUN, 1'b0, 1'b0, 1'b0, 0, 0);
        do_reset();
        idle(1);

        // Randomized frame mix, mostly back-to-back
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0, 1: begin
                    start = 16'($urandom);
                    if (it % 5 == 0) start[9:0] = 10'h3FE;
                    wq = {};
                    for (int unsigned n = $urandom_range(1, 4); n > 0; n--) wq.push_back($urandom);
                    send_load(1'($urandom_range(0, 1)), start);
                end
                2: begin
                    model_run = 1'b1;
                    send_byte(OP_RUN, 1'b0, 1'b0, 1'b0, 0, 0);
                    for (int unsigned n = $urandom_range(0, 3); n > 0; n--) begin
                        b = 8'($urandom);
                        if (b == OP_HALT) b = 8'h55;
                        send_byte(b, 1'b0, 1'b0, 1'b0, 0, 0);
                    end
                    model_run = 1'b0;
                    send_byte(OP_HALT, 1'b0, 1'b0, 1'b0, 0, 0);
                end
                3: begin
                    model_err = 1'b1;
                    send_byte(8'($urandom_range(5, 255)), 1'b0, 1'b0, 1'b0, 0, 0);
                end
                default: begin
                    send_byte(OP_HALT, 1'b0, 1'b0, 1'b0, 0, 0);
                end
            endcase
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
Hardware loader that fills the CPU's instruction and data memories from a byte stream. It holds the CPU core in reset until the load completes. It receives framed bytes over a valid/ready handshake, assembles 32-bit little-endian words, and issues single-cycle word writes to IMEM or DMEM. A RUN command releases the core; a HALT command puts it back into reset.

Parameters:
ADDR_W, 10, word-address width driven on mem_addr; addresses wrap modulo 2^ADDR_W.
CNT_W, 16, word-count width; fixed by the 2-byte count field.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  in_byte is valid this cycle.
in_byte  input  8  stream byte.
in_ready  output  1  loader accepts the byte; a transfer occurs when in_valid & in_ready.
mem_we  output  1  one-cycle word write strobe.
mem_sel  output  1  target memory: 0 = IMEM, 1 = DMEM.
mem_addr  output  ADDR_W  word address of the write.
mem_wdata  output  32  write word.
cpu_reset  output  1  reset to the CPU core; high = core held.
busy  output  1  a frame is in progress (state not IDLE/RUN).
err  output  1  sticky error flag: an unknown opcode was received.

Behaviour:
- Reset values:
  - state = IDLE, in_ready = 1, cpu_reset = 1.
  - mem_we = 0, mem_sel = 0, mem_addr = 0, mem_wdata = 0.
  - busy = 0, err = 0.
- Frame format: OP, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, then 4*CNT data bytes.
  - Data bytes arrive LSB first per word.
  - Opcodes: 0x01 = write IMEM, 0x02 = write DMEM, 0x03 = RUN, 0x04 = HALT.
  - RUN and HALT are single-byte frames.
- FSM states: IDLE, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, DATA, RUN. Every state advances only on a transfer.
  - IDLE:
    - 0x01/0x02: latch mem_sel, go to ADDR_LO.
    - 0x03: go to RUN, cpu_reset = 0 from the next cycle.
    - 0x04: stay in IDLE.
    - Any other value: err = 1, stay in IDLE.
  - ADDR_LO/ADDR_HI: load the 16-bit start address; the low ADDR_W bits are used.
  - CNT_LO/CNT_HI: load the count. If count == 0 on CNT_HI, return to IDLE with no write.
  - DATA:
    - A 2-bit byte index shifts bytes into the word assembly register.
    - On the 4th byte transfer: next cycle mem_we = 1 for exactly one cycle, with mem_addr = current address and mem_wdata = the assembled word.
    - The address then increments and wraps at 2^ADDR_W; the remaining count decrements.
    - When the count reaches 0, go to IDLE. Frames may follow back-to-back.
  - RUN:
    - cpu_reset = 0.
    - 0x04: cpu_reset = 1 from the next cycle, go to IDLE.
    - All other bytes are accepted and ignored; err is unaffected.
- in_ready is 1 in all states. Full throughput is one byte per cycle; a word write occurs at most every 4 cycles, so no backpressure is needed.
- mem_addr, mem_sel and mem_wdata hold their last values when mem_we = 0.
- cpu_reset stays 1 throughout IMEM/DMEM loads; memories are never written while the core runs.
- Reset mid-frame: the partial word is discarded and no write is issued; cpu_reset returns to 1 immediately (asynchronously).
- err clears only on reset.

Decomposition:
- Package mem_loader_pkg:
  - opcode constants OP_WR_IMEM = 8'h01, OP_WR_DMEM = 8'h02, OP_RUN = 8'h03, OP_HALT = 8'h04.
  - FSM state encoding.
  - MEM_SEL_IMEM = 0, MEM_SEL_DMEM = 1.
- One sub-module, word_assembler: byte shifter plus 2-bit index that emits word_valid and a 32-bit word on the 4th byte, with a clear input.
- The FSM and counters stay in mem_loader.

Test Plan:
- Reset release, no input -> cpu_reset = 1, mem_we = 0, busy = 0, err = 0, in_ready = 1.
- Bytes 01 04 00 02 00 | 13 00 50 00 | 93 00 10 00 -> two mem_we pulses:
  - mem_sel = 0, addr 4, data 0x00500013.
  - addr 5, data 0x00100093.
  - Each pulse is 1 cycle after its 4th byte; busy falls after the last byte.
- DMEM frame 02 FF 03 02 00 + 8 bytes, ADDR_W = 10 -> writes at addr 0x3FF then 0x000 (wrap), mem_sel = 1.
- Frame with count 00 00, then 03 -> no mem_we; cpu_reset drops 1 cycle after the 03 byte; 04 afterwards -> cpu_reset = 1, state IDLE.
- Byte 0x7E in IDLE -> err = 1 and stays 1 through a later valid IMEM load that writes correctly; err clears only on reset.
- Reset asserted after 2 of 4 data bytes, then released -> no mem_we. A new frame writes only its own word; the discarded bytes leave no trace in the assembled word.
